// File: rtl/hazard_pkg.sv
// Shared types and helpers for the pipeline hazard controller.
//   hz_state_t  : controller sequencing state
//   range_mask  : returns a vector with bits lo..hi set (MaxStages wide, callers slice)
//   Def*        : default stage-index constants for a 4-buffer pipeline
package hazard_pkg;

    localparam int unsigned MaxStages = 32;

    localparam int unsigned DefNumStages    = 4;
    localparam int unsigned DefBrResolveStg = 2;
    localparam int unsigned DefJmpResolveStg = 1;
    localparam int unsigned DefLoadStallStg = 2;
    localparam int unsigned DefMemTimeout   = 255;
    localparam int unsigned DefCntW         = 16;

    typedef enum logic [1:0] {
        RUN         = 2'd0,
        MEM_WAIT    = 2'd1,
        ALERT_DRAIN = 2'd2,
        ALERT_FLUSH = 2'd3
    } hz_state_t;

    // Bits lo..hi inclusive; empty when lo > hi.
    function automatic logic [MaxStages-1:0] range_mask(input int unsigned lo,
                                                        input int unsigned hi);
        logic [MaxStages-1:0] m;
        m = '0;
        for (int unsigned i = 0; i < MaxStages; i++) begin
            if (i >= lo && i <= hi) m[i] = 1'b1;
        end
        return m;
    endfunction

endpackage

// File: rtl/hazard_perf_cnt.sv
// Two independent saturating event counters.
//   clk, rst_n       : clock, asynchronous active-low reset
//   stall_inc_i      : count one stall cycle
//   flush_inc_i      : count one flush cycle
//   stall_cnt_o      : stall-cycle count, saturates at all-ones
//   flush_cnt_o      : flush-cycle count, saturates at all-ones
module hazard_perf_cnt #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             stall_inc_i,
    input  logic             flush_inc_i,
    output logic [CNT_W-1:0] stall_cnt_o,
    output logic [CNT_W-1:0] flush_cnt_o
);

    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (stall_inc_i && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + 1'b1;
        if (flush_inc_i && (flush_cnt_q != '1)) flush_cnt_d = flush_cnt_q + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign stall_cnt_o = stall_cnt_q;
    assign flush_cnt_o = flush_cnt_q;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: per-buffer stall/flush generation with alert drain/flush
// sequencing, deferred mispredict flush across memory stalls and a memory-stall timeout.
// Buffer 0 is IF/ID, buffer NUM_STAGES-1 is the last pipeline buffer.
// Optional event counters are built only when HAZARD_PERF_CNT_EN is defined; otherwise
// stall_cnt/flush_cnt are tied to zero.
//   clk, rst_n          : clock, asynchronous active-low reset
//   branch_mispredict   : mispredict resolved this cycle
//   mem_stall           : memory not ready
//   alert               : interrupt/exception request (level)
//   load_hazard         : load-use hazard
//   branch_call_jump    : taken call/jump redirect
//   stall, flush        : per-buffer hold / clear (combinational, zero in reset)
//   alert_ack           : one-cycle pulse when the alert flush is applied
//   mem_timeout         : sticky memory-stall timeout flag
//   busy                : controller not in RUN
//   stall_cnt, flush_cnt: stall-cycle / flush-cycle counts
module pipe_hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int unsigned NUM_STAGES      = DefNumStages,
    parameter int unsigned BR_RESOLVE_STG  = DefBrResolveStg,
    parameter int unsigned JMP_RESOLVE_STG = DefJmpResolveStg,
    parameter int unsigned LOAD_STALL_STG  = DefLoadStallStg,
    parameter int unsigned MEM_TIMEOUT     = DefMemTimeout,
    parameter int unsigned CNT_W           = DefCntW
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  branch_mispredict,
    input  logic                  mem_stall,
    input  logic                  alert,
    input  logic                  load_hazard,
    input  logic                  branch_call_jump,
    output logic [NUM_STAGES-1:0] stall,
    output logic [NUM_STAGES-1:0] flush,
    output logic                  alert_ack,
    output logic                  mem_timeout,
    output logic                  busy,
    output logic [CNT_W-1:0]      stall_cnt,
    output logic [CNT_W-1:0]      flush_cnt
);

    localparam int unsigned DrainW = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;
    localparam int unsigned ToW    = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;

    localparam logic [DrainW-1:0] DrainInit  = DrainW'(NUM_STAGES - 1);
    localparam logic [ToW-1:0]    TimeoutVal = ToW'(MEM_TIMEOUT);

    localparam logic [MaxStages-1:0] BrMaskW   = range_mask(0, BR_RESOLVE_STG);
    localparam logic [MaxStages-1:0] JmpMaskW  = range_mask(0, JMP_RESOLVE_STG);
    localparam logic [MaxStages-1:0] LoadMaskW = range_mask(0, LOAD_STALL_STG);
    // Slicing drops the bubble bit when LOAD_STALL_STG is already the last buffer.
    localparam logic [MaxStages-1:0] BubMaskW  = range_mask(LOAD_STALL_STG + 1,
                                                            LOAD_STALL_STG + 1);

    localparam logic [NUM_STAGES-1:0] BrMask   = BrMaskW[NUM_STAGES-1:0];
    localparam logic [NUM_STAGES-1:0] JmpMask  = JmpMaskW[NUM_STAGES-1:0];
    localparam logic [NUM_STAGES-1:0] LoadMask = LoadMaskW[NUM_STAGES-1:0];
    localparam logic [NUM_STAGES-1:0] BubMask  = BubMaskW[NUM_STAGES-1:0];
    localparam logic [NUM_STAGES-1:0] AllOnes  = '1;
    localparam logic [NUM_STAGES-1:0] FetchBit = NUM_STAGES'(1);

    hz_state_t         state_q, state_d;
    logic              pend_q, pend_d;
    logic [DrainW-1:0] drain_q, drain_d;
    logic [ToW-1:0]    to_q, to_d, to_inc;
    logic              mem_timeout_q, mem_timeout_d;

    logic [NUM_STAGES-1:0] stall_c, flush_c;
    logic                  ack_c;
    logic                  run_rules;

    assign to_inc = (to_q == TimeoutVal) ? to_q : to_q + 1'b1;

    always_comb begin
        state_d       = state_q;
        pend_d        = pend_q;
        drain_d       = drain_q;
        to_d          = to_q;
        mem_timeout_d = mem_timeout_q;
        stall_c       = '0;
        flush_c       = '0;
        ack_c         = 1'b0;
        run_rules     = 1'b0;

        unique case (state_q)
            RUN: run_rules = 1'b1;

            MEM_WAIT: begin
                if (mem_stall) begin
                    stall_c = AllOnes;
                    to_d    = to_inc;
                    if (branch_mispredict) pend_d = 1'b1;
                    if (to_inc == TimeoutVal) mem_timeout_d = 1'b1;
                end else begin
                    // Memory ready: this cycle is handled exactly as RUN would.
                    run_rules = 1'b1;
                    to_d      = '0;
                    state_d   = RUN;
                end
            end

            ALERT_DRAIN: begin
                if (branch_mispredict) pend_d = 1'b1;
                if (mem_stall) begin
                    stall_c = AllOnes;
                end else begin
                    // Only the fetch side holds; older instructions keep retiring.
                    stall_c = FetchBit;
                    if (drain_q <= DrainW'(1)) begin
                        drain_d = '0;
                        state_d = ALERT_FLUSH;
                    end else begin
                        drain_d = drain_q - 1'b1;
                    end
                end
            end

            ALERT_FLUSH: begin
                flush_c = AllOnes;
                ack_c   = 1'b1;
                pend_d  = 1'b0;
                state_d = RUN;
            end

            default: state_d = RUN;
        endcase

        if (run_rules) begin
            if (alert) begin
                flush_c = FetchBit;
                drain_d = DrainInit;
                state_d = ALERT_DRAIN;
            end else if (mem_stall) begin
                // Entry cycle of a memory stall counts toward the timeout.
                stall_c = AllOnes;
                to_d    = to_inc;
                state_d = MEM_WAIT;
                if (branch_mispredict) pend_d = 1'b1;
                if (to_inc == TimeoutVal) mem_timeout_d = 1'b1;
            end else if (branch_mispredict || pend_q) begin
                flush_c = BrMask;
                pend_d  = 1'b0;
            end else if (load_hazard) begin
                stall_c = LoadMask;
                flush_c = BubMask;
            end else if (branch_call_jump) begin
                flush_c = JmpMask;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= RUN;
            pend_q        <= 1'b0;
            drain_q       <= '0;
            to_q          <= '0;
            mem_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            pend_q        <= pend_d;
            drain_q       <= drain_d;
            to_q          <= to_d;
            mem_timeout_q <= mem_timeout_d;
        end
    end

    assign stall       = rst_n ? stall_c : '0;
    assign flush       = rst_n ? flush_c : '0;
    assign alert_ack   = rst_n & ack_c;
    assign mem_timeout = mem_timeout_q;
    assign busy        = (state_q != RUN);

`ifdef HAZARD_PERF_CNT_EN
    hazard_perf_cnt #(
        .CNT_W(CNT_W)
    ) u_perf_cnt (
        .clk        (clk),
        .rst_n      (rst_n),
        .stall_inc_i(|stall),
        .flush_inc_i(|flush),
        .stall_cnt_o(stall_cnt),
        .flush_cnt_o(flush_cnt)
    );
`else
    assign stall_cnt = '0;
    assign flush_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed scoreboard bench for pipe_hazard_ctrl (default parameters, 4 buffers).
module tb_pipe_hazard_ctrl;

    logic       clk;
    logic       rst_n;
    logic       branch_mispredict, mem_stall, alert, load_hazard, branch_call_jump;
    logic [3:0] stall, flush;
    logic       alert_ack, mem_timeout, busy;
    logic [15:0] stall_cnt, flush_cnt;

    // Input encoding: {mispredict, mem_stall, alert, load_hazard, call_jump}
    localparam logic [4:0] NONE = 5'b00000;
    localparam logic [4:0] BM   = 5'b10000;
    localparam logic [4:0] MS   = 5'b01000;
    localparam logic [4:0] AL   = 5'b00100;
    localparam logic [4:0] LH   = 5'b00010;
    localparam logic [4:0] BJ   = 5'b00001;

    typedef struct {
        string      tag;
        logic [3:0] st;
        logic [3:0] fl;
        logic       ack;
        logic       busy;
        logic       tmo;
    } exp_t;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;

    pipe_hazard_ctrl dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .branch_mispredict(branch_mispredict),
        .mem_stall        (mem_stall),
        .alert            (alert),
        .load_hazard      (load_hazard),
        .branch_call_jump (branch_call_jump),
        .stall            (stall),
        .flush            (flush),
        .alert_ack        (alert_ack),
        .mem_timeout      (mem_timeout),
        .busy             (busy),
        .stall_cnt        (stall_cnt),
        .flush_cnt        (flush_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Drive one cycle of inputs, queue the expected outputs, compare at the falling edge.
    task automatic step(input string tag, input logic [4:0] in_v, input logic [3:0] es,
                        input logic [3:0] ef, input logic ea, input logic eb, input logic et);
        exp_t e;
        e = '{tag: tag, st: es, fl: ef, ack: ea, busy: eb, tmo: et};
        sb.push_back(e);
        {branch_mispredict, mem_stall, alert, load_hazard, branch_call_jump} = in_v;
        @(negedge clk);
        if (sb.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL %s: scoreboard empty", tag);
        end else begin
            e = sb.pop_front();
            check_eq({e.tag, ".stall"}, 32'(stall), 32'(e.st));
            check_eq({e.tag, ".flush"}, 32'(flush), 32'(e.fl));
            check_eq({e.tag, ".ack"}, 32'(alert_ack), 32'(e.ack));
            check_eq({e.tag, ".busy"}, 32'(busy), 32'(e.busy));
            check_eq({e.tag, ".tmo"}, 32'(mem_timeout), 32'(e.tmo));
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        {branch_mispredict, mem_stall, alert, load_hazard, branch_call_jump} = BM | LH;
        #3;
        check_eq("rst.stall", 32'(stall), 32'h0);
        check_eq("rst.flush", 32'(flush), 32'h0);
        check_eq("rst.busy", 32'(busy), 32'h0);
        check_eq("rst.tmo", 32'(mem_timeout), 32'h0);
        {branch_mispredict, mem_stall, alert, load_hazard, branch_call_jump} = NONE;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Single-cycle hazards in RUN and their priority.
        step("bm",      BM,           4'h0, 4'b0111, 0, 0, 0);
        step("idle0",   NONE,         4'h0, 4'h0,    0, 0, 0);
        step("lh",      LH,           4'b0111, 4'b1000, 0, 0, 0);
        step("bj",      BJ,           4'h0, 4'b0011, 0, 0, 0);
        step("bm_lh_bj", BM | LH | BJ, 4'h0, 4'b0111, 0, 0, 0);
        step("lh_bj",   LH | BJ,      4'b0111, 4'b1000, 0, 0, 0);

        // Mispredict arriving during a memory stall is deferred.
        step("ms1",     MS,           4'hF, 4'h0, 0, 0, 0);
        step("ms2_bm",  MS | BM,      4'hF, 4'h0, 0, 1, 0);
        step("ms3",     MS,           4'hF, 4'h0, 0, 1, 0);
        step("ms4",     MS,           4'hF, 4'h0, 0, 1, 0);
        step("ms5",     MS,           4'hF, 4'h0, 0, 1, 0);
        step("ms6",     NONE,         4'h0, 4'b0111, 0, 1, 0);
        step("ms7",     NONE,         4'h0, 4'h0, 0, 0, 0);

        // Mispredict together with mem_stall in RUN.
        step("sim1",    MS | BM,      4'hF, 4'h0, 0, 0, 0);
        step("sim2",    NONE,         4'h0, 4'b0111, 0, 1, 0);
        step("sim3",    NONE,         4'h0, 4'h0, 0, 0, 0);

        // Alert sequence without memory stalls.
        step("al0",     AL,           4'h0, 4'b0001, 0, 0, 0);
        step("al1",     NONE,         4'b0001, 4'h0, 0, 1, 0);
        step("al2",     LH | BJ,      4'b0001, 4'h0, 0, 1, 0);
        step("al3",     NONE,         4'b0001, 4'h0, 0, 1, 0);
        step("al4",     NONE,         4'h0, 4'hF, 1, 1, 0);
        step("al5",     NONE,         4'h0, 4'h0, 0, 0, 0);

        // Alert drain held by mem_stall; mispredict in drain is dropped by the alert flush.
        step("ad0",     AL,           4'h0, 4'b0001, 0, 0, 0);
        step("ad1_bm",  BM,           4'b0001, 4'h0, 0, 1, 0);
        step("ad2_ms",  MS,           4'hF, 4'h0, 0, 1, 0);
        step("ad3",     NONE,         4'b0001, 4'h0, 0, 1, 0);
        step("ad4",     NONE,         4'b0001, 4'h0, 0, 1, 0);
        step("ad5",     NONE,         4'h0, 4'hF, 1, 1, 0);
        step("ad6",     NONE,         4'h0, 4'h0, 0, 0, 0);

        // Alert raised inside MEM_WAIT waits until memory is ready.
        step("am1",     MS,           4'hF, 4'h0, 0, 0, 0);
        step("am2",     MS | AL,      4'hF, 4'h0, 0, 1, 0);
        step("am3",     AL,           4'h0, 4'b0001, 0, 1, 0);
        step("am4",     NONE,         4'b0001, 4'h0, 0, 1, 0);
        step("am5",     NONE,         4'b0001, 4'h0, 0, 1, 0);
        step("am6",     NONE,         4'b0001, 4'h0, 0, 1, 0);
        step("am7",     NONE,         4'h0, 4'hF, 1, 1, 0);
        step("am8",     NONE,         4'h0, 4'h0, 0, 0, 0);

        // Memory-stall timeout: flag visible from the 256th stalled cycle, sticky afterwards.
        for (int i = 1; i <= 260; i++) begin
            step($sformatf("tmo%0d", i), MS, 4'hF, 4'h0, 0, (i > 1), (i >= 256));
        end
        step("tmo_drop", NONE,        4'h0, 4'h0, 0, 1, 1);
        step("tmo_run",  BJ,          4'h0, 4'b0011, 0, 0, 1);
        step("tmo_idle", NONE,        4'h0, 4'h0, 0, 0, 1);

        // Reset in the middle of an alert drain.
        step("rd0",     AL,           4'h0, 4'b0001, 0, 0, 1);
        step("rd1",     NONE,         4'b0001, 4'h0, 0, 1, 1);
        rst_n = 1'b0;
        {branch_mispredict, mem_stall, alert, load_hazard, branch_call_jump} = BM;
        #1;
        check_eq("rd_rst.stall", 32'(stall), 32'h0);
        check_eq("rd_rst.flush", 32'(flush), 32'h0);
        check_eq("rd_rst.busy", 32'(busy), 32'h0);
        check_eq("rd_rst.tmo", 32'(mem_timeout), 32'h0);
        {branch_mispredict, mem_stall, alert, load_hazard, branch_call_jump} = NONE;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        for (int i = 0; i < 5; i++) begin
            step($sformatf("rd_post%0d", i), NONE, 4'h0, 4'h0, 0, 0, 0);
        end
        step("rd_bm",   BM,           4'h0, 4'b0111, 0, 0, 0);

        if (sb.size() != 0) begin
            n_vec++;
            n_err++;
            $display("FAIL sb_drain: %0d entries left, expected 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
